// File: rtl/aes_ctrl_pkg.sv
// Shared types for the AES-128 inverse-cipher control path.
// The datapath decodes op_t directly, so the encoding below is part of the interface.
package aes_ctrl_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_ROUND_W    = 4;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LOAD = 3'd1,
    OP_ARK  = 3'd2,
    OP_ISR  = 3'd3,
    OP_ISB  = 3'd4,
    OP_IMC  = 3'd5
  } op_t;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_KEYEXP = 4'd1,
    ST_LOAD   = 4'd2,
    ST_ARK0   = 4'd3,
    ST_ISR    = 4'd4,
    ST_ISB    = 4'd5,
    ST_ARK    = 4'd6,
    ST_IMC    = 4'd7,
    ST_DONE   = 4'd8
  } ctrl_state_t;

endpackage

// File: rtl/aes_decrypt_ctrl.sv
// Sequencer stepping the AES-128 datapath through InvCipher order after key expansion.
// Build option AES_DECRYPT_CTRL_FAST_IMC_EN: InvMixColumns on all four columns in one cycle.
module aes_decrypt_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int SB_LAT     = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       io_ready,
  input  logic       key_exp_done,
  output logic       key_exp_start,
  output logic [2:0] op_sel,
  output logic       state_we,
  output logic [3:0] round_idx,
  output logic [1:0] imc_col,
  output logic       busy,
  output logic       aes_ready
);

  localparam int SB_W = (SB_LAT > 1) ? $clog2(SB_LAT) : 1;
  localparam logic [AES_ROUND_W-1:0] ROUND_INIT = AES_ROUND_W'(NUM_ROUNDS);
  localparam logic [AES_ROUND_W-1:0] ROUND_ONE  = AES_ROUND_W'(1);
  localparam logic [SB_W-1:0]        SB_LAST    = SB_W'(SB_LAT - 1);
  localparam logic [SB_W-1:0]        SB_ONE     = SB_W'(1);
`ifdef AES_DECRYPT_CTRL_FAST_IMC_EN
  localparam logic [1:0] COL_LAST = 2'd0;
`else
  localparam logic [1:0] COL_LAST = 2'd3;
`endif

  ctrl_state_t            state_q, state_d;
  logic [AES_ROUND_W-1:0] round_q, round_d;
  logic [1:0]             col_q, col_d;
  logic [SB_W-1:0]        sb_q, sb_d;

  logic                   key_exp_start_q, key_exp_start_d;
  op_t                    op_sel_q, op_sel_d;
  logic                   state_we_q, state_we_d;
  logic [AES_ROUND_W-1:0] round_idx_q, round_idx_d;
  logic [1:0]             imc_col_q, imc_col_d;
  logic                   busy_q, busy_d;
  logic                   aes_ready_q, aes_ready_d;

  logic in_busy_s;
  assign in_busy_s = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // Next-state and counter update; dropping io_ready in any busy state aborts to IDLE.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    col_d   = col_q;
    sb_d    = sb_q;
    if (in_busy_s && !io_ready) begin
      state_d = ST_IDLE;
      round_d = ROUND_INIT;
      col_d   = 2'd0;
      sb_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          round_d = ROUND_INIT;
          col_d   = 2'd0;
          sb_d    = '0;
          if (io_ready) begin
            state_d = ST_KEYEXP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_KEYEXP: begin
          if (key_exp_done) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_KEYEXP;
          end
        end
        ST_LOAD: state_d = ST_ARK0;
        ST_ARK0: begin
          state_d = ST_ISR;
          round_d = round_q - ROUND_ONE;
        end
        ST_ISR: begin
          state_d = ST_ISB;
          sb_d    = '0;
        end
        ST_ISB: begin
          if (sb_q == SB_LAST) begin
            state_d = ST_ARK;
            sb_d    = '0;
          end else begin
            sb_d    = sb_q + SB_ONE;
          end
        end
        // The final round key (index 0) is applied without a following InvMixColumns.
        ST_ARK: begin
          col_d = 2'd0;
          if (round_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IMC;
          end
        end
        ST_IMC: begin
          if (col_q == COL_LAST) begin
            state_d = ST_ISR;
            col_d   = 2'd0;
            round_d = round_q - ROUND_ONE;
          end else begin
            col_d   = col_q + 2'd1;
          end
        end
        ST_DONE: begin
          if (io_ready) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          round_d = ROUND_INIT;
          col_d   = 2'd0;
          sb_d    = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs line up with state_q.
  always_comb begin
    key_exp_start_d = (state_q == ST_IDLE) && (state_d == ST_KEYEXP);
    op_sel_d        = OP_NONE;
    state_we_d      = 1'b0;
    round_idx_d     = (state_d == ST_IDLE) ? '0 : round_d;
    imc_col_d       = 2'd0;
    busy_d          = (state_d != ST_IDLE) && (state_d != ST_DONE);
    aes_ready_d     = (state_d == ST_DONE);
    case (state_d)
      ST_LOAD: begin
        op_sel_d   = OP_LOAD;
        state_we_d = 1'b1;
      end
      ST_ARK0, ST_ARK: begin
        op_sel_d   = OP_ARK;
        state_we_d = 1'b1;
      end
      ST_ISR: begin
        op_sel_d   = OP_ISR;
        state_we_d = 1'b1;
      end
      ST_ISB: begin
        op_sel_d   = OP_ISB;
        state_we_d = (sb_d == SB_LAST);
      end
      ST_IMC: begin
        op_sel_d   = OP_IMC;
        state_we_d = 1'b1;
        imc_col_d  = col_d;
      end
      default: begin
        op_sel_d   = OP_NONE;
        state_we_d = 1'b0;
      end
    endcase
  end

  // State, counters and outputs; asynchronous reset returns everything to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      round_q         <= ROUND_INIT;
      col_q           <= 2'd0;
      sb_q            <= '0;
      key_exp_start_q <= 1'b0;
      op_sel_q        <= OP_NONE;
      state_we_q      <= 1'b0;
      round_idx_q     <= '0;
      imc_col_q       <= 2'd0;
      busy_q          <= 1'b0;
      aes_ready_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      round_q         <= round_d;
      col_q           <= col_d;
      sb_q            <= sb_d;
      key_exp_start_q <= key_exp_start_d;
      op_sel_q        <= op_sel_d;
      state_we_q      <= state_we_d;
      round_idx_q     <= round_idx_d;
      imc_col_q       <= imc_col_d;
      busy_q          <= busy_d;
      aes_ready_q     <= aes_ready_d;
    end
  end

  assign key_exp_start = key_exp_start_q;
  assign op_sel        = op_sel_q;
  assign state_we      = state_we_q;
  assign round_idx     = round_idx_q;
  assign imc_col       = imc_col_q;
  assign busy          = busy_q;
  assign aes_ready     = aes_ready_q;

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Self-checking bench for aes_decrypt_ctrl: randomized runs against an InvCipher step-list model.
// Honours AES_DECRYPT_CTRL_FAST_IMC_EN when the build defines it.
module tb_aes_decrypt_ctrl;
  import aes_ctrl_pkg::*;

  localparam int NR     = AES_NUM_ROUNDS;
  localparam int SB_LAT = 1;
`ifdef AES_DECRYPT_CTRL_FAST_IMC_EN
  localparam int IMC_CYC = 1;
`else
  localparam int IMC_CYC = 4;
`endif

  logic       clk;
  logic       reset_n;
  logic       io_ready;
  logic       key_exp_done;
  logic       key_exp_start;
  logic [2:0] op_sel;
  logic       state_we;
  logic [3:0] round_idx;
  logic [1:0] imc_col;
  logic       busy;
  logic       aes_ready;

  aes_decrypt_ctrl #(.NUM_ROUNDS(NR), .SB_LAT(SB_LAT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .io_ready     (io_ready),
    .key_exp_done (key_exp_done),
    .key_exp_start(key_exp_start),
    .op_sel       (op_sel),
    .state_we     (state_we),
    .round_idx    (round_idx),
    .imc_col      (imc_col),
    .busy         (busy),
    .aes_ready    (aes_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [2:0] op;
    logic       we;
    logic [3:0] rnd;
    logic [1:0] col;
  } step_t;

  step_t trace[$];

  // Expected per-cycle datapath commands from LOAD up to the cycle before DONE.
  function automatic void build_trace();
    step_t s;
    trace.delete();
    s = '{op: 3'(OP_LOAD), we: 1'b1, rnd: 4'(NR), col: 2'd0};
    trace.push_back(s);
    s = '{op: 3'(OP_ARK), we: 1'b1, rnd: 4'(NR), col: 2'd0};
    trace.push_back(s);
    for (int r = NR - 1; r >= 0; r--) begin
      s = '{op: 3'(OP_ISR), we: 1'b1, rnd: 4'(r), col: 2'd0};
      trace.push_back(s);
      for (int k = 0; k < SB_LAT; k++) begin
        s = '{op: 3'(OP_ISB), we: (k == SB_LAT - 1), rnd: 4'(r), col: 2'd0};
        trace.push_back(s);
      end
      s = '{op: 3'(OP_ARK), we: 1'b1, rnd: 4'(r), col: 2'd0};
      trace.push_back(s);
      if (r != 0) begin
        for (int c = 0; c < IMC_CYC; c++) begin
          s = '{op: 3'(OP_IMC), we: 1'b1, rnd: 4'(r), col: 2'(c)};
          trace.push_back(s);
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq(tag, {25'd0, busy, aes_ready, state_we, key_exp_start, op_sel, round_idx, imc_col}, 32'd0);
  endtask

  // One request: dly = KEYEXP wait, abort_at/rst_at = trace index to abort/reset after (-1 none).
  task automatic run(input int dly, input int abort_at, input int rst_at, input int hold);
    int starts;
    int wes;
    int kx;
    starts = 0;
    wes    = 0;
    kx     = (dly == 0) ? 1 : dly;
    io_ready     = 1'b1;
    key_exp_done = (dly == 0);
    for (int k = 0; k < kx; k++) begin
      step();
      check_eq("keyexp_busy_op_we", {busy, state_we, op_sel}, {1'b1, 1'b0, 3'(OP_NONE)});
      starts += int'(key_exp_start);
      if (k == dly - 1) key_exp_done = 1'b1;
    end
    for (int i = 0; i < trace.size(); i++) begin
      step();
      check_eq($sformatf("op[%0d]", i), {29'd0, op_sel}, {29'd0, trace[i].op});
      check_eq($sformatf("we[%0d]", i), {31'd0, state_we}, {31'd0, trace[i].we});
      check_eq("busy_run", {busy, aes_ready}, 2'b10);
      if (trace[i].op == 3'(OP_ARK)) check_eq($sformatf("round_idx[%0d]", i), round_idx, trace[i].rnd);
      if (trace[i].op == 3'(OP_IMC)) check_eq($sformatf("imc_col[%0d]", i), imc_col, trace[i].col);
      wes    += int'(state_we);
      starts += int'(key_exp_start);
      if (i == abort_at) begin
        io_ready     = 1'b0;
        key_exp_done = 1'b0;
        step();
        check_idle("abort_idle");
        return;
      end
      if (i == rst_at) begin
        #2 reset_n = 1'b0;
        #1 check_idle("async_rst_immediate");
        io_ready     = 1'b0;
        key_exp_done = 1'b0;
        #2 reset_n = 1'b1;
        step();
        check_idle("post_rst_idle");
        return;
      end
    end
    check_eq("key_exp_start_pulses", starts, 1);
    check_eq("we_count", wes, 2 + (NR - 1) * (3 + IMC_CYC) + 3);
    key_exp_done = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      step();
      check_eq("done_hold", {aes_ready, busy, state_we, op_sel}, {1'b1, 1'b0, 1'b0, 3'(OP_NONE)});
    end
    io_ready = 1'b0;
    step();
    check_idle("release_idle");
  endtask

  initial begin
    int imc5;
    int isb7;
    int ab;
    reset_n      = 1'b0;
    io_ready     = 1'b0;
    key_exp_done = 1'b0;
    build_trace();
    repeat (2) step();
    check_idle("reset_state");
    reset_n = 1'b1;
    step();
    check_idle("idle_no_request");

    imc5 = -1;
    isb7 = -1;
    for (int i = 0; i < trace.size(); i++) begin
      if (imc5 < 0 && trace[i].op == 3'(OP_IMC) && trace[i].rnd == 4'd5 &&
          trace[i].col == ((IMC_CYC > 1) ? 2'd2 : 2'd0)) imc5 = i;
      if (isb7 < 0 && trace[i].op == 3'(OP_ISB) && trace[i].rnd == 4'd7) isb7 = i;
    end

    run(5, -1, -1, 10);      // nominal, DONE held 10 extra cycles
    run(0, -1, -1, 0);       // key_exp_done already high, immediate restart after DONE
    run(2, imc5, -1, 0);     // abort during round 5 InvMixColumns
    run(3, -1, isb7, 0);     // asynchronous reset mid-ISB
    run(1, -1, -1, 2);

    for (int it = 0; it < 8; it++) begin
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, trace.size() - 1)) : -1;
      run(int'($urandom_range(0, 6)), ab, -1, int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
